l2_responder: RTL



---
 rtl/l2_responder_pkg.sv | 18 +
 rtl/l2_line_store.sv | 40 ++++
 rtl/l2_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/l2_responder_pkg.sv
// Shared types and constants for the L2 responder and its line store.
package l2_responder_pkg;

  // Responder control states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StRespond = 2'd2
  } l2_state_e;

  // Encoding of the request read/write flag.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Lines are 32 bytes, so the line index starts at address bit 5.
  localparam int unsigned LineOffset = 5;

endpackage

// File: rtl/l2_line_store.sv
// Single-port line storage: synchronous write, registered read, cleared by reset.
module l2_line_store
  import l2_responder_pkg::*;
#(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned LinesLog  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [LinesLog-1:0]  idx_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned NumLines = 1 << LinesLog;

  logic [DataWidth-1:0] mem_q [NumLines];
  logic [DataWidth-1:0] rdata_q;

  // Storage array and read register; one access (read or write) per enabled edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumLines; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_responder.sv
// L2 responder: pops one request, waits a fixed access latency, then answers the
// originating L1, holding the response while that L1's response FIFO is full.
module l2_responder
  import l2_responder_pkg::*;
#(
  parameter int unsigned num_L1s        = 2,
  parameter int unsigned num_L1s_log    = 1,
  parameter int unsigned addr_width     = 32,
  parameter int unsigned data_width     = 256,
  parameter int unsigned cpu_id_width   = 2,
  parameter int unsigned mem_lines_log  = 4,
  parameter int unsigned access_latency = 4
) (
  input  logic                    clk_L2,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    req_valid,
  input  logic                    req_rw,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [data_width-1:0]   req_data,
  input  logic [cpu_id_width-1:0] req_id,
  input  logic [num_L1s_log-1:0]  req_which_L1,
  output logic                    req_accept,
  input  logic [num_L1s-1:0]      resp_full,
  output logic                    resp_valid,
  output logic                    resp_rw,
  output logic [addr_width-1:0]   resp_addr,
  output logic [data_width-1:0]   resp_data,
  output logic [cpu_id_width-1:0] resp_id,
  output logic [num_L1s_log-1:0]  resp_which_L1,
  output logic                    busy
);

  localparam int unsigned CntW = (access_latency > 1) ? $clog2(access_latency) : 1;
  localparam logic [CntW-1:0] LatLoad = CntW'(access_latency - 1);

  l2_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic                    rw_q;
  logic [addr_width-1:0]   addr_q;
  logic [data_width-1:0]   data_q;
  logic [cpu_id_width-1:0] id_q;
  logic [num_L1s_log-1:0]  which_q;

  logic                    accept;
  logic                    store_en;
  logic                    resp_fire;
  logic [data_width-1:0]   line_rdata;

  // Next-state, counter and strobe decode; nothing advances while enable is low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    store_en  = 1'b0;
    resp_fire = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            accept  = 1'b1;
            cnt_d   = LatLoad;
            state_d = StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            store_en = 1'b1;
            state_d  = StRespond;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StRespond: begin
          if (!resp_full[which_q]) begin
            resp_fire = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk_L2) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on the accepting edge; held until the next request.
  always_ff @(posedge clk_L2) begin
    if (!reset_n) begin
      rw_q    <= RW_READ;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      which_q <= '0;
    end else if (accept) begin
      rw_q    <= req_rw;
      addr_q  <= req_addr;
      data_q  <= req_data;
      id_q    <= req_id;
      which_q <= req_which_L1;
    end
  end

  // Write or read happens on the ACCESS->RESPOND edge; upper address bits alias.
  l2_line_store #(
    .DataWidth (data_width),
    .LinesLog  (mem_lines_log)
  ) u_line_store (
    .clk_i   (clk_L2),
    .rst_ni  (reset_n),
    .en_i    (store_en),
    .we_i    (rw_q == RW_WRITE),
    .idx_i   (addr_q[LineOffset +: mem_lines_log]),
    .wdata_i (data_q),
    .rdata_o (line_rdata)
  );

  // Outputs are forced low while reset is asserted.
  always_comb begin
    req_accept    = reset_n & accept;
    resp_valid    = reset_n & resp_fire;
    busy          = reset_n & (state_q != StIdle);
    resp_rw       = reset_n & rw_q;
    resp_addr     = reset_n ? addr_q : '0;
    resp_id       = reset_n ? id_q : '0;
    resp_which_L1 = reset_n ? which_q : '0;
    resp_data     = '0;
    if (reset_n) begin
      resp_data = (rw_q == RW_WRITE) ? data_q : line_rdata;
    end
  end

endmodule
